serial_to_parallel_hs: RTL and testbench



---
 rtl/s2p_pkg.sv | 19 +
 rtl/s2p_interface.sv | 38 +++
 rtl/s2p_shift_core.sv | 49 ++++
 rtl/serial_to_parallel_hs.sv | 90 +++++++++
 tb/tb_serial_to_parallel_hs.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/s2p_pkg.sv
// Shared types and defaults for the handshaked serial-to-parallel converter.
package s2p_pkg;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  localparam int S2P_N_DEF         = 8;
  localparam bit S2P_MSB_FIRST_DEF = 1'b1;

  // Bit-order reversal of a 64-bit value, handy for comparing the two orderings.
  function automatic logic [63:0] s2p_reverse64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = w[63-i];
    return r;
  endfunction

endpackage

// File: rtl/s2p_interface.sv
// Bundle of every converter signal, for connecting producers, consumers and checkers.
interface s2p_interface
  import s2p_pkg::*;
#(
  parameter int N     = S2P_N_DEF,
  parameter int CNT_W = $clog2(N)
) (
  input logic clk
);

  logic             reset;
  logic             data_in;
  logic             bit_valid;
  logic             flush;
  logic             clr_ovr;
  logic [N-1:0]     data_out;
  logic             out_valid;
  logic             out_ready;
  logic             full_tick;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  modport producer (
    input  clk, bit_cnt,
    output reset, data_in, bit_valid, flush, clr_ovr
  );

  modport consumer (
    input  clk, data_out, out_valid, full_tick, overrun,
    output out_ready
  );

  modport monitor (
    input clk, reset, data_in, bit_valid, flush, clr_ovr, data_out,
          out_valid, out_ready, full_tick, bit_cnt, overrun
  );

endinterface

// File: rtl/s2p_shift_core.sv
// Shift register and bit counter; reports the assembled word on the edge the last bit arrives.
module s2p_shift_core
  import s2p_pkg::*;
#(
  parameter int N         = S2P_N_DEF,
  parameter bit MSB_FIRST = S2P_MSB_FIRST_DEF,
  parameter int CNT_W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             bit_valid,
  input  logic             flush,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_done,
  output logic [N-1:0]     word
);

  logic [N-1:0] sreg;
  logic [N-1:0] sreg_next;
  logic         accept;
  logic         last_bit;

  if (MSB_FIRST) begin : g_msb_first
    assign sreg_next = {sreg[N-2:0], data_in};
  end else begin : g_lsb_first
    assign sreg_next = {data_in, sreg[N-1:1]};
  end

  // Flush outranks a coincident bit, so that bit can never complete a word.
  assign accept    = bit_valid && !flush;
  assign last_bit  = (bit_cnt == CNT_W'(N - 1));
  assign word_done = accept && last_bit;
  assign word      = sreg_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (flush) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sreg    <= sreg_next;
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_to_parallel_hs.sv
// Serial-to-parallel converter with a one-word holding register behind valid/ready,
// plus a sticky overrun flag for words dropped while the consumer stalls.
module serial_to_parallel_hs
  import s2p_pkg::*;
#(
  parameter int N         = S2P_N_DEF,
  parameter bit MSB_FIRST = S2P_MSB_FIRST_DEF,
  parameter int CNT_W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             bit_valid,
  input  logic             flush,
  input  logic             clr_ovr,
  output logic [N-1:0]     data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full_tick,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  logic         word_done;
  logic [N-1:0] word;
  hold_state_t  hold_state;
  hold_state_t  hold_state_next;
  logic         load;
  logic         drop;

  s2p_shift_core #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_shift_core (
    .clk       (clk),
    .rst       (reset),
    .data_in   (data_in),
    .bit_valid (bit_valid),
    .flush     (flush),
    .bit_cnt   (bit_cnt),
    .word_done (word_done),
    .word      (word)
  );

  // Handshake: a word transfers on any edge where out_valid && out_ready. out_valid
  // stays high until that transfer; a word completing in the same edge as a transfer
  // replaces the old one, and one completing while FULL without out_ready is dropped.
  always_comb begin
    hold_state_next = hold_state;
    load            = 1'b0;
    drop            = 1'b0;
    case (hold_state)
      HOLD_EMPTY: begin
        if (word_done) begin
          hold_state_next = HOLD_FULL;
          load            = 1'b1;
        end
      end
      HOLD_FULL: begin
        if (word_done) begin
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          hold_state_next = HOLD_EMPTY;
        end
      end
      default: hold_state_next = HOLD_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_state <= HOLD_EMPTY;
      data_out   <= '0;
      full_tick  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      hold_state <= hold_state_next;
      full_tick  <= load;
      if (load) data_out <= word;
      // A drop on the same edge as clr_ovr keeps the flag set.
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  assign out_valid = (hold_state == HOLD_FULL);

endmodule

// File: tb/tb_serial_to_parallel_hs.sv
// Directed bench: two converters (MSB-first and LSB-first) share one stimulus stream.
module tb_serial_to_parallel_hs;
  import s2p_pkg::*;

  localparam int N     = S2P_N_DEF;
  localparam int CNT_W = $clog2(N);

  logic clk;
  s2p_interface #(.N(N)) bus (.clk(clk));

  logic [N-1:0]     lsb_data;
  logic             lsb_valid;
  logic             lsb_tick;
  logic [CNT_W-1:0] lsb_cnt;
  logic             lsb_ovr;

  int n_cmp = 0;
  int n_err = 0;
  int ticks;

  serial_to_parallel_hs #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .reset     (bus.reset),
    .data_in   (bus.data_in),
    .bit_valid (bus.bit_valid),
    .flush     (bus.flush),
    .clr_ovr   (bus.clr_ovr),
    .data_out  (bus.data_out),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .full_tick (bus.full_tick),
    .bit_cnt   (bus.bit_cnt),
    .overrun   (bus.overrun)
  );

  serial_to_parallel_hs #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .reset     (bus.reset),
    .data_in   (bus.data_in),
    .bit_valid (bus.bit_valid),
    .flush     (bus.flush),
    .clr_ovr   (bus.clr_ovr),
    .data_out  (lsb_data),
    .out_valid (lsb_valid),
    .out_ready (bus.out_ready),
    .full_tick (lsb_tick),
    .bit_cnt   (lsb_cnt),
    .overrun   (lsb_ovr)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  function automatic logic [N-1:0] rev(input logic [N-1:0] w);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = w[N-1-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change just after a falling edge, outputs are read there too.
  task automatic send_bit(input logic b);
    bus.data_in   = b;
    bus.bit_valid = 1'b1;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    bus.data_in   = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] w, output int tk);
    tk = 0;
    for (int i = N - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (bus.full_tick) tk++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.reset     = 1'b1;
    bus.data_in   = 1'b0;
    bus.bit_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.clr_ovr   = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("rst_data",  bus.data_out,  0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_tick",  bus.full_tick, 0);
    check("rst_cnt",   bus.bit_cnt,   0);
    check("rst_ovr",   bus.overrun,   0);
    bus.reset = 1'b0;

    // A5 with the consumer always ready
    bus.out_ready = 1'b1;
    send_word(8'hA5, ticks);
    check("a5_data",     bus.data_out,  8'hA5);
    check("a5_valid",    bus.out_valid, 1);
    check("a5_tick",     bus.full_tick, 1);
    check("a5_lsb_data", lsb_data,      rev(8'hA5));
    check("a5_ticks",    ticks,         1);
    idle(1);
    check("a5_drain_valid", bus.out_valid, 0);
    check("a5_drain_tick",  bus.full_tick, 0);
    check("a5_drain_hold",  bus.data_out,  8'hA5);

    // Bits 1,1,0,0,0,0,0,0
    send_word(8'hC0, ticks);
    check("c0_msb_data", bus.data_out, 8'hC0);
    check("c0_lsb_data", lsb_data,     8'h03);
    idle(1);

    // Stalled consumer: second word dropped
    bus.out_ready = 1'b0;
    send_word(8'h3C, ticks);
    check("3c_valid", bus.out_valid, 1);
    check("3c_data",  bus.data_out,  8'h3C);
    check("3c_ticks", ticks,         1);
    send_word(8'hC3, ticks);
    check("drop_data",     bus.data_out,  8'h3C);
    check("drop_lsb_data", lsb_data,      rev(8'h3C));
    check("drop_ovr",      bus.overrun,   1);
    check("drop_ticks",    ticks,         0);
    check("drop_valid",    bus.out_valid, 1);
    check("drop_cnt",      bus.bit_cnt,   0);
    bus.out_ready = 1'b1;
    idle(1);
    check("accept_valid", bus.out_valid, 0);
    check("accept_data",  bus.data_out,  8'h3C);
    check("accept_ovr",   bus.overrun,   1);
    bus.out_ready = 1'b0;
    bus.clr_ovr   = 1'b1;
    idle(1);
    bus.clr_ovr = 1'b0;
    check("clr_ovr", bus.overrun, 0);

    // Ready rises on the very edge 22 completes
    send_word(8'h11, ticks);
    check("11_valid", bus.out_valid, 1);
    check("11_data",  bus.data_out,  8'h11);
    for (int i = N - 1; i >= 1; i--) send_bit(1'(8'h22 >> i));
    bus.out_ready = 1'b1;
    send_bit(1'b0);
    check("22_data",     bus.data_out,  8'h22);
    check("22_valid",    bus.out_valid, 1);
    check("22_ovr",      bus.overrun,   0);
    check("22_tick",     bus.full_tick, 1);
    check("22_lsb_data", lsb_data,      8'h44);
    idle(1);
    check("22_drain_valid", bus.out_valid, 0);

    // Flush beats a coincident bit
    repeat (5) send_bit(1'b1);
    check("pre_flush_cnt", bus.bit_cnt, 5);
    bus.flush = 1'b1;
    send_bit(1'b1);
    bus.flush = 1'b0;
    check("flush_cnt",   bus.bit_cnt,   0);
    check("flush_valid", bus.out_valid, 0);
    send_word(8'hF0, ticks);
    check("f0_data",     bus.data_out, 8'hF0);
    check("f0_lsb_data", lsb_data,     8'h0F);
    check("f0_ticks",    ticks,        1);
    idle(1);

    // Asynchronous reset while FULL with bits pending
    bus.out_ready = 1'b0;
    send_word(8'h5A, ticks);
    send_word(8'hA5, ticks);
    repeat (3) send_bit(1'b1);
    check("pre_rst_cnt",   bus.bit_cnt,   3);
    check("pre_rst_valid", bus.out_valid, 1);
    check("pre_rst_ovr",   bus.overrun,   1);
    #2 bus.reset = 1'b1;
    #1;
    check("arst_data",      bus.data_out,  0);
    check("arst_valid",     bus.out_valid, 0);
    check("arst_tick",      bus.full_tick, 0);
    check("arst_cnt",       bus.bit_cnt,   0);
    check("arst_ovr",       bus.overrun,   0);
    check("arst_lsb_valid", lsb_valid,     0);
    @(negedge clk);
    bus.reset     = 1'b0;
    bus.out_ready = 1'b1;
    send_word(8'h81, ticks);
    check("81_data",     bus.data_out, 8'h81);
    check("81_lsb_data", lsb_data,     rev(8'h81));
    check("81_tick",     bus.full_tick, 1);
    check("81_lsb_cnt",  lsb_cnt,      0);
    check("81_lsb_ovr",  lsb_ovr,      0);
    check("81_lsb_tick", lsb_tick,     1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
